// File: rtl/uart_tx_feeder.sv
// Byte FIFO and transmit sequencer feeding uart_tx: queues host bytes and hands
// them out one at a time, waiting for each tx_done before starting the next.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state, next_state;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              tx_done_q;
    logic              done_edge;
    logic              wr_accept;
    logic              pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign wr_accept = wr_en & ~full;
    assign pop       = (state == IDLE) & ~empty;
    assign done_edge = tx_done & ~tx_done_q;
    assign tx_start  = (state == START);
    assign busy      = (state != IDLE);

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A tx_done level already high when WAIT_DONE is entered is ignored; only a new rising edge ends the wait.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_edge) begin
                    next_state = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data   <= 8'h00;
            gap_cnt   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
            if (state == WAIT_DONE && done_edge) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a small behavioural uart_tx stand-in
// that records every started byte and answers with a delayed tx_done pulse.
module tb_uart_tx_feeder;

    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int GAP_CYCLES = 2;
    localparam int RESP_DELAY = 6;
    localparam int NUM_VECS   = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic              busy;

    logic              man_done  = 1'b0;
    logic              resp_done = 1'b0;
    logic              resp_en   = 1'b0;
    logic              pending   = 1'b0;
    int                wait_cnt  = 0;
    logic [7:0]        rx_q [$];

    int                n_checks = 0;
    int                n_fail   = 0;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       done;
        logic [4:0] exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_start;
        logic       exp_busy;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [NUM_VECS];

    assign tx_done = man_done | resp_done;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    // Stand-in for uart_tx: capture on tx_start, then pulse tx_done after RESP_DELAY idle clocks when enabled.
    always @(negedge clk) begin
        if (tx_start) begin
            rx_q.push_back(tx_data);
            pending  = 1'b1;
            wait_cnt = 0;
        end else if (resp_done) begin
            resp_done = 1'b0;
            pending   = 1'b0;
        end else if (!busy) begin
            pending = 1'b0;
        end else if (pending && resp_en) begin
            if (wait_cnt == RESP_DELAY) begin
                resp_done = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string name);
        int cyc = 0;
        while (rx_q.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_output(name, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((busy || !empty) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_output(name, 32'(busy), 32'd0);
    endtask

    initial begin
        automatic int base;
        automatic logic [7:0] burst [10] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5,
                                             8'hF6, 8'h07, 8'h18, 8'h29, 8'h3A};

        // wr  data   done cnt  emp   full  start busy  tx_data
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[6]  = '{1'b1, 8'hB2, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB2};

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_empty",    32'(empty),    32'd1);
        check_output("reset_full",     32'(full),     32'd0);
        check_output("reset_count",    32'(count),    32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        check_output("reset_tx_start", 32'(tx_start), 32'd0);
        check_output("reset_busy",     32'(busy),     32'd0);
        check_output("reset_tx_data",  32'(tx_data),  32'h00);
        reset = 1'b1;
        @(negedge clk);

        // Single byte, then a byte whose tx_done level is already high before WAIT_DONE.
        for (int i = 0; i < NUM_VECS; i++) begin
            man_done = vecs[i].done;
            apply_stimulus(vecs[i].wr_en, vecs[i].wr_data);
            check_output($sformatf("vec%0d_count", i),    32'(count),    32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d_empty", i),    32'(empty),    32'(vecs[i].exp_empty));
            check_output($sformatf("vec%0d_full", i),     32'(full),     32'(vecs[i].exp_full));
            check_output($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].exp_start));
            check_output($sformatf("vec%0d_busy", i),     32'(busy),     32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d_tx_data", i),  32'(tx_data),  32'(vecs[i].exp_data));
        end
        man_done = 1'b0;

        base    = rx_q.size();
        resp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, burst[i]);
        end
        check_output("burst_peak_count", 32'(count), 32'd9);
        wait_rx(base + 10, "burst_rx_count");
        wait_idle("burst_idle");
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("burst_byte%0d", i), 32'(rx_q[base + i]), 32'(burst[i]));
        end
        check_output("burst_no_repeat", 32'(rx_q.size()), 32'(base + 10));
        check_output("burst_empty",     32'(empty),       32'd1);

        resp_en = 1'b0;
        base    = rx_q.size();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, 8'(i));
        end
        check_output("fill_count",    32'(count),    32'd16);
        check_output("fill_full",     32'(full),     32'd1);
        check_output("fill_overflow", 32'(overflow), 32'd0);
        check_output("fill_busy",     32'(busy),     32'd1);
        apply_stimulus(1'b1, 8'h11);
        check_output("ovf_overflow", 32'(overflow), 32'd1);
        check_output("ovf_count",    32'(count),    32'd16);
        check_output("ovf_full",     32'(full),     32'd1);
        resp_en = 1'b1;
        wait_rx(base + 17, "fill_rx_count");
        wait_idle("fill_idle");
        for (int i = 0; i < 17; i++) begin
            check_output($sformatf("fill_byte%0d", i), 32'(rx_q[base + i]), 32'(i));
        end
        check_output("fill_dropped", 32'(rx_q.size()), 32'(base + 17));
        check_output("ovf_sticky",   32'(overflow),    32'd1);

        // Write lands on the same edge as the IDLE pop with three bytes queued.
        resp_en = 1'b0;
        base    = rx_q.size();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 8'h40 + 8'(i));
        end
        check_output("sim_count_pre", 32'(count), 32'd3);
        apply_stimulus(1'b0, 8'h00);
        man_done = 1'b1;
        apply_stimulus(1'b0, 8'h00);
        man_done = 1'b0;
        apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00);
        check_output("sim_idle_busy",  32'(busy),  32'd0);
        check_output("sim_idle_count", 32'(count), 32'd3);
        apply_stimulus(1'b1, 8'h44);
        check_output("sim_count",    32'(count),    32'd3);
        check_output("sim_tx_start", 32'(tx_start), 32'd1);
        check_output("sim_tx_data",  32'(tx_data),  32'h41);
        resp_en = 1'b1;
        wait_rx(base + 5, "sim_rx_count");
        wait_idle("sim_idle");
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("sim_byte%0d", i), 32'(rx_q[base + i]), 32'(8'h40 + 8'(i)));
        end

        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 8'h60 + 8'(i));
        end
        check_output("mid_count_pre", 32'(count), 32'd4);
        check_output("mid_busy_pre",  32'(busy),  32'd1);
        reset = 1'b0;
        #1;
        check_output("mid_busy",     32'(busy),     32'd0);
        check_output("mid_count",    32'(count),    32'd0);
        check_output("mid_empty",    32'(empty),    32'd1);
        check_output("mid_tx_start", 32'(tx_start), 32'd0);
        check_output("mid_tx_data",  32'(tx_data),  32'h00);
        check_output("mid_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 8'h00);
            check_output($sformatf("mid_quiet%0d", i), 32'(tx_start), 32'd0);
        end
        base    = rx_q.size();
        resp_en = 1'b1;
        apply_stimulus(1'b1, 8'h5A);
        wait_rx(base + 1, "mid_rx_count");
        wait_idle("mid_idle");
        check_output("mid_new_byte", 32'(rx_q[base]), 32'h5A);
        check_output("mid_only_one", 32'(rx_q.size()), 32'(base + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus transmit sequencer that sits directly upstream of uart_tx.
- Accepts bytes from a host-side write port and buffers up to DEPTH of them.
- Presents one byte at a time on uart_tx data_in, issues a one-cycle transmit pulse, then waits for uart_tx to report tx_done before sending the next byte.
- Lets software or a test driver queue a burst of bytes without handshaking each one.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, >= 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- GAP_CYCLES, 2, idle clocks inserted after each tx_done before the next tx_start; 0 is legal.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write strobe; byte accepted on a rising edge when wr_en=1 and full=0.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when wr_en=1 while full=1.
- tx_data  output  8  byte driven to uart_tx data_in; held stable from tx_start until tx_done.
- tx_start  output  1  one-cycle pulse to uart_tx transmit.
- tx_done  input  1  from uart_tx; completion is detected on its rising edge.
- busy  output  1  high in every sequencer state except IDLE.

Behaviour:
- Reset (reset=0, async) forces:
  - State IDLE; rd_ptr = wr_ptr = 0; count = 0.
  - empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, busy=0.
  - Gap counter 0; tx_done_q = 0.
  - FIFO contents are not cleared.
- Reset mid-transfer discards all queued bytes and any byte in flight. No tx_start is issued until a new write arrives after reset is released.
- FIFO:
  - Write stores wr_data at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - Pop (sequencer only) reads mem[rd_ptr]; rd_ptr increments and wraps.
  - Write and pop on the same edge: both pointers advance, count unchanged.
  - Write while full: data dropped, pointers unchanged, overflow set, and it stays set until reset.
  - A write arriving while full, on the same edge as a pop, is still dropped, because full is evaluated before the edge.
  - full = (count == DEPTH); empty = (count == 0). Both are registered-derived with no combinational path from wr_en.
- tx_done_q registers tx_done every cycle; done_edge = tx_done & ~tx_done_q.
- Sequencer FSM:
  - IDLE: if empty=0, pop the FIFO, latch tx_data <= mem[rd_ptr], go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: stay until done_edge. Then go to GAP if GAP_CYCLES>0 (load the gap counter with GAP_CYCLES-1), else go to IDLE.
  - GAP: decrement the gap counter each cycle; go to IDLE when it reaches 0.
- A tx_done level that is already high on entry to WAIT_DONE does not count. A fresh rising edge is required.
- Latency: a byte written at edge N into an empty FIFO with the sequencer in IDLE is popped at edge N+1. tx_start is high between edges N+1 and N+2.
- Back-to-back: the next tx_start follows done_edge by GAP_CYCLES+2 cycles.
- tx_data changes only in IDLE on a pop.
- count includes only queued bytes; the byte in flight is excluded.

Test Plan:
- Reset: hold reset=0 for 3 clocks -> empty=1, full=0, count=0, overflow=0, tx_start=0, busy=0, tx_data=8'h00.
- Single byte: write 8'hA1 into an idle block, loop tx through uart_tx/uart_rx ->
  - tx_start pulses exactly once, 2 cycles after the wr_en edge, with tx_data=8'hA1.
  - rx_data=8'hA1 at rx_done.
  - busy returns to 0 GAP_CYCLES+1 cycles after the tx_done rising edge.
- Burst order: write 8'hA1, B2, C3, D4, E5, F6, 07, 18, 29, 3A on consecutive clocks -> rx receives all ten in order, no repeats; count peaks at 9 (the first byte is already popped); empty=1 after the last pop.
- Full/overflow: hold tx_done low, write 17 bytes 8'h00..8'h10 ->
  - One byte goes in flight; count reaches 16 and full=1.
  - The 18th write (8'h11) is dropped and sets overflow=1.
  - After releasing tx_done, the bytes emitted are exactly 8'h00..8'h10.
- Simultaneous write and pop: with count=3 and the sequencer entering IDLE, assert wr_en on the pop edge -> count stays 3; pointers wrap correctly after DEPTH+5 total writes.
- Reset mid-transfer: assert reset while in WAIT_DONE with 4 bytes queued -> immediate IDLE, count=0, tx_start stays 0 after release until a new write, and the next transmitted byte is that new write.
